// File: rtl/wide_alu_seq_pkg.sv
// Shared types for the wide ALU sequencer.
// Provides:
//   wop_e         - wide operation requested by the execute stage
//   wseq_state_e  - sequencer state encoding
//   instruction_s - 8-bit ALU opcodes that the sequencer drives
//   WSEQ_NBYTES_MAX - largest supported operand width in bytes
package wide_alu_seq_pkg;

  localparam int unsigned WSEQ_NBYTES_MAX = 8;

  typedef enum logic [1:0] {
    WOP_ADD  = 2'd0,
    WOP_AND  = 2'd1,
    WOP_OR   = 2'd2,
    WOP_SRL1 = 2'd3
  } wop_e;

  typedef enum logic [2:0] {
    IDLE,
    ADD_LO,
    ADD_CI,
    LOGIC,
    SHIFT,
    DONE
  } wseq_state_e;

  // Subset of the core ALU opcode set used by the sequencer.
  typedef enum logic [3:0] {
    MOV  = 4'd0,
    ADDU = 4'd1,
    ADDI = 4'd2,
    AND  = 4'd3,
    OR   = 4'd4,
    SRLV = 4'd5
  } instruction_s;

endpackage

// File: rtl/wide_alu_seq_byte_lane.sv
// Byte lane for the wide ALU sequencer.
// Selects byte k of operands A and B and merges a written byte into the
// working result R at position k.
// Ports:
//   a_i, b_i     - latched wide operands
//   r_i          - current working result
//   k_i          - byte index
//   wr_en_i      - write wr_byte_i into R[k]
//   wr_byte_i    - byte to write
//   a_byte_o     - A[k]
//   b_byte_o     - B[k]
//   r_next_o     - R with the optional write applied
module wseq_byte_lane #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned KW     = 2
) (
  input  logic [8*NBYTES-1:0] a_i,
  input  logic [8*NBYTES-1:0] b_i,
  input  logic [8*NBYTES-1:0] r_i,
  input  logic [KW-1:0]       k_i,
  input  logic                wr_en_i,
  input  logic [7:0]          wr_byte_i,
  output logic [7:0]          a_byte_o,
  output logic [7:0]          b_byte_o,
  output logic [8*NBYTES-1:0] r_next_o
);

  always_comb begin
    a_byte_o = '0;
    b_byte_o = '0;
    r_next_o = r_i;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k_i == KW'(i)) begin
        a_byte_o = a_i[8*i +: 8];
        b_byte_o = b_i[8*i +: 8];
        if (wr_en_i) begin
          r_next_o[8*i +: 8] = wr_byte_i;
        end
      end
    end
  end

endmodule

// File: rtl/wide_alu_seq.sv
// Multi-precision operation sequencer for the shared 8-bit ALU.
// Runs one NBYTES-wide ADD/AND/OR/SRL1 byte by byte through the ALU,
// chaining carry or shift-in bits between passes.
// Configuration: define WIDE_ALU_SEQ_SRL_EN to support WOP_SRL1; without it
// WOP_SRL1 completes after one cycle with err_o set.
// Ports:
//   clk_i, rst_n_i         - clock, async active-low reset
//   start_i, op_i, a_i, b_i - request (taken only while ready_o)
//   ready_o, busy_o        - idle / owns the ALU inputs
//   done_o, err_o          - completion pulse, unsupported-op flag
//   result_o, carry_o      - wide result and final carry/shift-out bit
//   alu_rs_o, alu_rt_o, alu_im_o, alu_op_o - ALU operand/opcode drive
//   alu_result_i, alu_carry_i              - ALU response
module wide_alu_seq
  import wide_alu_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic [8*NBYTES-1:0] a_i,
  input  logic [8*NBYTES-1:0] b_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [8*NBYTES-1:0] result_o,
  output logic                carry_o,
  output logic [7:0]          alu_rs_o,
  output logic [7:0]          alu_rt_o,
  output logic [1:0]          alu_im_o,
  output instruction_s        alu_op_o,
  input  logic [7:0]          alu_result_i,
  input  logic                alu_carry_i
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned KW   = $clog2(NBYTES);
  localparam logic [KW-1:0] LAST = KW'(NBYTES - 1);

  wseq_state_e   state_q, state_d;
  wop_e          op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  result_q, result_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    psum_q, psum_d;
  logic          c_q, c_d;
  logic          c1_q, c1_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;

  logic [7:0]    a_byte, b_byte;
  logic          wr_en;
  logic [7:0]    wr_byte;

  wseq_byte_lane #(
    .NBYTES (NBYTES),
    .KW     (KW)
  ) u_lane (
    .a_i       (a_q),
    .b_i       (b_q),
    .r_i       (r_q),
    .k_i       (k_q),
    .wr_en_i   (wr_en),
    .wr_byte_i (wr_byte),
    .a_byte_o  (a_byte),
    .b_byte_o  (b_byte),
    .r_next_o  (r_d)
  );

  // Lane write control kept apart from the main next-state block so the
  // merged R feeds back into result_d without a combinational block loop.
  always_comb begin
    wr_en   = 1'b0;
    wr_byte = alu_result_i;
    case (state_q)
      ADD_CI, LOGIC: wr_en = 1'b1;
`ifdef WIDE_ALU_SEQ_SRL_EN
      SHIFT: begin
        wr_en   = 1'b1;
        wr_byte = {c_q, alu_result_i[6:0]};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    psum_d   = psum_q;
    c_d      = c_q;
    c1_d     = c1_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    alu_rs_o = '0;
    alu_rt_o = '0;
    alu_im_o = '0;
    alu_op_o = MOV;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d   = a_i;
          b_d   = b_i;
          op_d  = wop_e'(op_i);
          c_d   = 1'b0;
          c1_d  = 1'b0;
          err_d = 1'b0;
          k_d   = '0;
          case (wop_e'(op_i))
            WOP_ADD:         state_d = ADD_LO;
            WOP_AND, WOP_OR: state_d = LOGIC;
            default: begin
`ifdef WIDE_ALU_SEQ_SRL_EN
              k_d     = LAST;
              state_d = SHIFT;
`else
              err_d   = 1'b1;
              state_d = DONE;
`endif
            end
          endcase
        end
      end

      ADD_LO: begin
        alu_rs_o = a_byte;
        alu_rt_o = b_byte;
        alu_op_o = ADDU;
        psum_d   = alu_result_i;
        c1_d     = alu_carry_i;
        state_d  = ADD_CI;
      end

      // Carry-in pass always runs so latency is independent of data.
      ADD_CI: begin
        alu_rs_o = psum_q;
        alu_im_o = {1'b0, c_q};
        alu_op_o = ADDI;
        c_d      = c1_q | alu_carry_i;
        if (k_q == LAST) begin
          state_d  = DONE;
          result_d = r_d;
          carry_d  = c1_q | alu_carry_i;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ADD_LO;
        end
      end

      LOGIC: begin
        alu_rs_o = a_byte;
        alu_rt_o = b_byte;
        alu_op_o = (op_q == WOP_AND) ? AND : OR;
        if (k_q == LAST) begin
          state_d  = DONE;
          result_d = r_d;
          carry_d  = 1'b0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

`ifdef WIDE_ALU_SEQ_SRL_EN
      // Walks from the top byte down; c carries the bit shifted out of the
      // byte above into bit 7 of the current byte.
      SHIFT: begin
        alu_rs_o = a_byte;
        alu_im_o = 2'd1;
        alu_op_o = SRLV;
        c_d      = a_byte[0];
        if (k_q == '0) begin
          state_d  = DONE;
          result_d = r_d;
          carry_d  = a_byte[0];
        end else begin
          k_d = k_q - KW'(1);
        end
      end
`endif

      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      op_q     <= WOP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      k_q      <= '0;
      psum_q   <= '0;
      c_q      <= 1'b0;
      c1_q     <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      result_q <= result_d;
      k_q      <= k_d;
      psum_q   <= psum_d;
      c_q      <= c_d;
      c1_q     <= c1_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE);
  assign busy_o   = (state_q != IDLE) && (state_q != DONE);
  assign err_o    = done_o && err_q;
  assign result_o = result_q;
  assign carry_o  = carry_q;

endmodule
